// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush sequencer for the
// 5-stage RISC-V pipeline. Drives the PC enable, IF_ID hold/zero controls
// and ID_EX bubble insertion, and counts stall and flush events.
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             is_stall,
  output logic             is_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_events,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    UNUSED = 2'd3
  } state_e;

  // Count reloaded on entry: the detection cycle itself is the first cycle.
  localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_events_q, flush_events_q;
  logic             stall_inc, flush_inc;
  logic             lu;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
          (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state and control outputs; a taken branch overrides everything.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    is_stall     = 1'b0;
    is_flush     = 1'b0;
    id_ex_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (ex_branch_taken) begin
      is_flush     = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (lu) begin
            pc_write     = 1'b0;
            is_stall     = 1'b1;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = STALL_RELOAD;
            end
          end
        end
        STALL: begin
          pc_write     = 1'b0;
          is_stall     = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        FLUSH: begin
          is_flush     = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    // Pipeline is frozen with every control low while reset is held.
    if (reset) begin
      pc_write     = 1'b0;
      is_stall     = 1'b0;
      is_flush     = 1'b0;
      id_ex_bubble = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  // State, sequence counter and wrap-around event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      stall_events_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_inc) stall_events_q <= stall_events_q + CNT_W'(1);
      if (flush_inc) flush_events_q <= flush_events_q + CNT_W'(1);
    end
  end

  assign state        = state_q;
  assign stall_events = stall_events_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: drives four differently parameterised hazard_ctrl copies
// with the same directed vectors and checks them every cycle against a
// cycles-remaining model, plus hand-computed literal expectations.
module tb_hazard_ctrl;

  localparam int N = 4;

  logic       clock;
  logic       reset;
  logic [4:0] idRs1, idRs2, exRd;
  logic       idUsesRs1, idUsesRs2, exMemRead, exBranchTaken;

  logic [N-1:0]        pcW, stallO, flushO, bubO;
  logic [N-1:0][1:0]   stO;
  logic [N-1:0][31:0]  seO, feO;

  int checks = 0;
  int errors = 0;

  // Per-instance parameters mirrored for the model.
  int pS [N] = '{1, 3, 4, 2};
  int pF [N] = '{2, 2, 2, 1};
  int pW [N] = '{32, 32, 4, 8};

  // Model state: cycles still to come in the running sequence, and event tallies.
  int              mStallLeft [N];
  int              mFlushLeft [N];
  longint unsigned evS [N];
  longint unsigned evF [N];

  hazard_ctrl u0 (
    .clk(clock), .reset(reset), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2), .ex_rd(exRd),
    .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
    .pc_write(pcW[0]), .is_stall(stallO[0]), .is_flush(flushO[0]),
    .id_ex_bubble(bubO[0]), .state(stO[0]),
    .stall_events(seO[0]), .flush_events(feO[0])
  );

  hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(32)) u1 (
    .clk(clock), .reset(reset), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2), .ex_rd(exRd),
    .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
    .pc_write(pcW[1]), .is_stall(stallO[1]), .is_flush(flushO[1]),
    .id_ex_bubble(bubO[1]), .state(stO[1]),
    .stall_events(seO[1]), .flush_events(feO[1])
  );

  hazard_ctrl #(.STALL_CYCLES(4), .FLUSH_CYCLES(2), .CNT_W(4)) u2 (
    .clk(clock), .reset(reset), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2), .ex_rd(exRd),
    .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
    .pc_write(pcW[2]), .is_stall(stallO[2]), .is_flush(flushO[2]),
    .id_ex_bubble(bubO[2]), .state(stO[2]),
    .stall_events(seO[2][3:0]), .flush_events(feO[2][3:0])
  );

  hazard_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(8)) u3 (
    .clk(clock), .reset(reset), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2), .ex_rd(exRd),
    .ex_mem_read(exMemRead), .ex_branch_taken(exBranchTaken),
    .pc_write(pcW[3]), .is_stall(stallO[3]), .is_flush(flushO[3]),
    .id_ex_bubble(bubO[3]), .state(stO[3]),
    .stall_events(seO[3][7:0]), .flush_events(feO[3][7:0])
  );

  assign seO[2][31:4] = '0;
  assign feO[2][31:4] = '0;
  assign seO[3][31:8] = '0;
  assign feO[3][31:8] = '0;

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic luNow();
    return exMemRead && (exRd != 5'd0) &&
           ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
  endfunction

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0h, expected %0h",
               name, k, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic us1, input logic us2,
                               input logic [4:0] rd, input logic mr,
                               input logic br);
    idRs1 = rs1; idRs2 = rs2; idUsesRs1 = us1; idUsesRs2 = us2;
    exRd = rd; exMemRead = mr; exBranchTaken = br;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idleCycles(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // Model advance: a branch (re)starts a flush and cancels any stall; an
  // active sequence counts down; otherwise a hazard starts a stall.
  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        mStallLeft[k] <= 0;
        mFlushLeft[k] <= 0;
        evS[k]        <= 0;
        evF[k]        <= 0;
      end else if (exBranchTaken) begin
        mFlushLeft[k] <= pF[k] - 1;
        mStallLeft[k] <= 0;
        evF[k]        <= (evF[k] + 1) % (64'd1 << pW[k]);
      end else if (mFlushLeft[k] > 0) begin
        mFlushLeft[k] <= mFlushLeft[k] - 1;
      end else if (mStallLeft[k] > 0) begin
        mStallLeft[k] <= mStallLeft[k] - 1;
      end else if (luNow()) begin
        mStallLeft[k] <= pS[k] - 1;
        evS[k]        <= (evS[k] + 1) % (64'd1 << pW[k]);
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clock) begin
    for (int k = 0; k < N; k++) begin
      logic       ePc, eSt, eFl, eBu;
      logic [1:0] eState;
      ePc = 1'b1; eSt = 1'b0; eFl = 1'b0; eBu = 1'b0;
      eState = (mFlushLeft[k] > 0) ? 2'd2 : (mStallLeft[k] > 0) ? 2'd1 : 2'd0;
      if (reset) begin
        ePc = 1'b0;
        eState = 2'd0;
      end else if (exBranchTaken || mFlushLeft[k] > 0) begin
        eFl = 1'b1; eBu = 1'b1;
      end else if (mStallLeft[k] > 0 || luNow()) begin
        ePc = 1'b0; eSt = 1'b1; eBu = 1'b1;
      end
      checkOutput("pc_write", k, 32'(pcW[k]), 32'(ePc));
      checkOutput("is_stall", k, 32'(stallO[k]), 32'(eSt));
      checkOutput("is_flush", k, 32'(flushO[k]), 32'(eFl));
      checkOutput("id_ex_bubble", k, 32'(bubO[k]), 32'(eBu));
      checkOutput("state", k, 32'(stO[k]), 32'(eState));
      checkOutput("stall_events", k, seO[k], 32'(evS[k]));
      checkOutput("flush_events", k, feO[k], 32'(evF[k]));
    end
  end

  // Directed scenarios with literal expectations that pin the model.
  initial begin
    reset = 1'b1;
    idle();
    #1;
    checkOutput("rst_pc_write", 0, 32'(pcW[0]), 32'd0);
    checkOutput("rst_bubble", 0, 32'(bubO[0]), 32'd0);
    checkOutput("rst_state", 0, 32'(stO[0]), 32'd0);
    checkOutput("rst_stall_events", 0, seO[0], 32'd0);
    step();
    step();
    reset = 1'b0;
    idleCycles(2);

    // Single load-use with default parameters.
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    #1;
    checkOutput("lu_stall", 0, 32'(stallO[0]), 32'd1);
    checkOutput("lu_bubble", 0, 32'(bubO[0]), 32'd1);
    checkOutput("lu_pc_hold", 0, 32'(pcW[0]), 32'd0);
    step();
    idle();
    #1;
    checkOutput("lu_pc_resume", 0, 32'(pcW[0]), 32'd1);
    checkOutput("lu_stall_end", 0, 32'(stallO[0]), 32'd0);
    checkOutput("lu_count", 0, seO[0], 32'd1);
    idleCycles(5);

    // Near-miss patterns that must not stall.
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("x0_no_stall", 0, 32'(stallO[0]), 32'd0);
    step();
    applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    #1;
    checkOutput("rs2_unused_no_stall", 0, 32'(stallO[0]), 32'd0);
    checkOutput("rs2_unused_pc", 0, 32'(pcW[0]), 32'd1);
    step();
    idle();
    #1;
    checkOutput("no_false_count", 0, seO[0], 32'd1);
    idleCycles(2);

    // Three-cycle stall with the hazard held across the whole sequence.
    applyStimulus(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    checkOutput("s3_c0_stall", 1, 32'(stallO[1]), 32'd1);
    checkOutput("s3_c0_state", 1, 32'(stO[1]), 32'd0);
    step();
    #1;
    checkOutput("s3_c1_stall", 1, 32'(stallO[1]), 32'd1);
    checkOutput("s3_c1_state", 1, 32'(stO[1]), 32'd1);
    step();
    #1;
    checkOutput("s3_c2_stall", 1, 32'(stallO[1]), 32'd1);
    checkOutput("s3_c2_state", 1, 32'(stO[1]), 32'd1);
    step();
    idle();
    #1;
    checkOutput("s3_c3_stall", 1, 32'(stallO[1]), 32'd0);
    checkOutput("s3_c3_state", 1, 32'(stO[1]), 32'd0);
    checkOutput("s3_count", 1, seO[1], 32'd2);
    idleCycles(6);

    // Branch pulse, then a second branch inside the flush window.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checkOutput("br_flush_c0", 0, 32'(flushO[0]), 32'd1);
    checkOutput("br_pc_c0", 0, 32'(pcW[0]), 32'd1);
    step();
    idle();
    #1;
    checkOutput("br_flush_c1", 0, 32'(flushO[0]), 32'd1);
    checkOutput("br_state_c1", 0, 32'(stO[0]), 32'd2);
    step();
    #1;
    checkOutput("br_flush_done", 0, 32'(flushO[0]), 32'd0);
    checkOutput("br_count", 0, feO[0], 32'd1);
    step();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    #1;
    checkOutput("br2_flush_c1", 0, 32'(flushO[0]), 32'd1);
    step();
    idle();
    #1;
    checkOutput("br2_flush_c2", 0, 32'(flushO[0]), 32'd1);
    checkOutput("br2_state_c2", 0, 32'(stO[0]), 32'd2);
    step();
    #1;
    checkOutput("br2_flush_done", 0, 32'(flushO[0]), 32'd0);
    checkOutput("br2_count", 0, feO[0], 32'd3);
    idleCycles(4);

    // Branch aborts a four-cycle stall on its second cycle.
    applyStimulus(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    checkOutput("ab_stall_c0", 2, 32'(stallO[2]), 32'd1);
    step();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checkOutput("ab_state_c1", 2, 32'(stO[2]), 32'd1);
    checkOutput("ab_stall_c1", 2, 32'(stallO[2]), 32'd0);
    checkOutput("ab_flush_c1", 2, 32'(flushO[2]), 32'd1);
    step();
    idle();
    #1;
    checkOutput("ab_state_c2", 2, 32'(stO[2]), 32'd2);
    idleCycles(4);

    // Reset in the middle of a flush.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    idle();
    #1;
    checkOutput("pre_rst_state", 0, 32'(stO[0]), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_flush", 0, 32'(flushO[0]), 32'd0);
    checkOutput("mid_rst_pc", 0, 32'(pcW[0]), 32'd0);
    checkOutput("mid_rst_state", 0, 32'(stO[0]), 32'd0);
    checkOutput("mid_rst_count", 0, feO[0], 32'd0);
    step();
    step();
    reset = 1'b0;
    idleCycles(1);

    // Sixteen back-to-back branches wrap the 4-bit counter to zero.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step();
    idle();
    #1;
    checkOutput("wrap_count_w4", 2, feO[2], 32'd0);
    checkOutput("wrap_count_w32", 0, feO[0], 32'd16);
    checkOutput("wrap_count_w8", 3, feO[3], 32'd16);
    idleCycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. Detects load-use hazards between the ID and EX stages and taken-branch redirects resolved in EX. Sequences the PC write enable, the IF/ID stall and flush controls (`is_stall`, `is_flush`), and the ID/EX bubble insertion for a configurable number of cycles. Keeps wrap-around event counters for stalls and flushes. Sits beside the IF_ID and ID_EX pipeline registers and drives their control inputs.

## Interface
- `STALL_CYCLES`, default 1: bubbles inserted per load-use hazard; legal 1..15.
- `FLUSH_CYCLES`, default 2: cycles `is_flush` is held per taken branch; legal 1..15.
- `CNT_W`, default 32: width of the event counters.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_branch_taken`  in  1  the EX instruction redirects the PC this cycle.
- `pc_write`  out  1  PC register update enable.
- `is_stall`  out  1  hold the IF_ID register.
- `is_flush`  out  1  zero the IF_ID register.
- `id_ex_bubble`  out  1  load a NOP into ID_EX.
- `state`  out  2  current FSM state: 0 = IDLE, 1 = STALL, 2 = FLUSH.
- `stall_events`, `flush_events`  out  `CNT_W` each  event counters.

## Operation
- Hazard condition `lu`: `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
- A 4-bit down-counter `cnt` tracks the remaining cycles of a STALL or FLUSH sequence.
- Outputs are combinational from `state`, `lu` and `ex_branch_taken`. Branch has priority over load-use in every state.
- Branch cycle (`ex_branch_taken`=1, any state):
  - Outputs: `is_flush`=1, `id_ex_bubble`=1, `pc_write`=1, `is_stall`=0.
  - Next state: FLUSH with `cnt`=`FLUSH_CYCLES`-1 if `FLUSH_CYCLES`>1, else IDLE.
  - `flush_events` increments.
  - A branch during STALL aborts the stall. A branch during FLUSH restarts the count.
- IDLE, `lu`=1, no branch:
  - Outputs: `is_stall`=1, `id_ex_bubble`=1, `pc_write`=0.
  - `stall_events` increments.
  - Next state: STALL with `cnt`=`STALL_CYCLES`-1 if `STALL_CYCLES`>1, else IDLE.
- IDLE, no event: `pc_write`=1, all other controls 0.
- STALL, no branch: `is_stall`=1, `id_ex_bubble`=1, `pc_write`=0. `cnt` decrements; return to IDLE on the edge where `cnt`==1. `lu` is ignored in STALL and no new event is counted.
- FLUSH, no branch: `is_flush`=1, `id_ex_bubble`=1, `pc_write`=1. `cnt` decrements; return to IDLE on the edge where `cnt`==1.
- `is_stall` and `is_flush` are never both 1.
- Counters wrap modulo 2^`CNT_W` with no saturation.
- State encoding 3 is unreachable. If it is ever entered, the FSM goes to IDLE on the next edge with all controls 0 and `pc_write`=1.

## Timing
- Reset asserted (asynchronous):
  - `state`=IDLE, `cnt`=0, both counters 0.
  - Outputs forced to `pc_write`=0, `is_stall`=0, `is_flush`=0, `id_ex_bubble`=0 while `reset` is high.
- Reset mid-sequence abandons the STALL or FLUSH immediately. After `reset` falls, the first edge evaluates from IDLE.
- Zero-latency response: controls assert in the same cycle the hazard or branch input is seen.
- A load-use hazard holds the PC for exactly `STALL_CYCLES` consecutive cycles.
- A taken branch holds `is_flush` for exactly `FLUSH_CYCLES` consecutive cycles, unless another branch extends the sequence.
- Counters update on the same edge that ends the event's detection cycle. They are visible in the following cycle.

## Test plan
- Load-use, default parameters: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 for one cycle → `is_stall`=1, `id_ex_bubble`=1 and `pc_write`=0 for 1 cycle, then `pc_write`=1; `stall_events`=1.
- No false hazard: `ex_rd`=0 with `id_rs1`=0; `ex_rd`=7 with `id_rs2`=7 but `id_uses_rs2`=0 → no stall, counters stay 0.
- `STALL_CYCLES`=3, hazard held high throughout → `is_stall` high for exactly 3 cycles, `state` sequence 0,1,1,0; `stall_events`=1.
- Branch, default parameters: `ex_branch_taken` pulse → `is_flush` high for 2 cycles with `pc_write`=1 throughout; `flush_events`=1. Second branch in the FLUSH cycle → `is_flush` high for 3 cycles total; `flush_events`=2.
- Branch during `STALL_CYCLES`=4 stall, 2nd cycle → `is_stall` drops and `is_flush` rises in that same cycle; `state`=FLUSH next cycle.
- Reset mid-FLUSH, then `CNT_W`=4 wrap test: after 16 branches `flush_events`=0. Reset mid-FLUSH → all outputs at reset values immediately, `state`=0.
